// File: rtl/serial_adder.sv
// Bit-serial adder built on one full adder; done pulses WIDTH+2 cycles after start is taken, start ignored until idle.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a_in - b_in via ~b_in with carry-in forced to 1).

module fa (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             fa_s;
    logic             fa_co;

    always_comb begin
        b_load = b_in;
        c_load = c_in;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b_in;
            c_load = 1'b1;
        end
`endif
    end

    fa u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .s     (fa_s),
        .c_out (fa_co)
    );

    // busy/done are registered from the state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= {fa_s, psum[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= {fa_s, psum[WIDTH-1:1]};
                        c_out <= fa_co;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder at WIDTH=8 against a plain-arithmetic model.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return {(a >= b), d};
    endfunction

    // Issues one start pulse, then watches until done; lat counts cycles after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb,
                         output int lat, output int bcyc, output logic [W-1:0] s, output logic co,
                         output bit both);
        @(negedge clk);
        a_in = a; b_in = b; c_in = ci; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sb;
`endif
        @(negedge clk);
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
        lat = 0; bcyc = 0; both = 0; s = '0; co = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) bcyc++;
            if (busy && done) both = 1;
            if (done) begin
                lat = k; s = sum; co = c_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, c_out, sum} !== {3'b000, {W{1'b0}}}) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b c_out=%b sum=%h exp all zero", busy, done, c_out, sum);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bcyc; logic [W-1:0] s; logic co; bit both;
        do_op(8'h3C, 8'h05, 1'b0, 1'b0, lat, bcyc, s, co, both);
        checks++;
        if (lat !== W + 2) begin errors++; $display("FAIL latency got %0d exp %0d", lat, W + 2); end
        checks++;
        if (bcyc !== W) begin errors++; $display("FAIL busy_cycles got %0d exp %0d", bcyc, W); end
        checks++;
        if ({co, s} !== 9'h041) begin errors++; $display("FAIL add_3c_05 got %b_%h exp 0_41", co, s); end
        checks++;
        if (both) begin errors++; $display("FAIL busy_and_done got 1 exp 0"); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", done); end
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat, bcyc, s, co, both);
        checks++;
        if ({co, s} !== 9'h100) begin errors++; $display("FAIL add_ff_01 got %b_%h exp 1_00", co, s); end
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bcyc, s, co, both);
        checks++;
        if ({co, s} !== 9'h1FF) begin errors++; $display("FAIL add_ff_ff_1 got %b_%h exp 1_ff", co, s); end
    endtask

    task automatic test_random();
        int lat, bcyc; logic [W-1:0] s; logic co; bit both;
        logic [W-1:0] a, b; logic ci; logic [W:0] exp;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
            exp = ref_add(a, b, ci);
            do_op(a, b, ci, 1'b0, lat, bcyc, s, co, both);
            checks++;
            if ({co, s} !== exp || lat !== W + 2) begin
                errors++;
                $display("FAIL random_add %h+%h+%b got %b_%h lat %0d exp %b_%h lat %0d",
                         a, b, ci, co, s, lat, exp[W], exp[W-1:0], W + 2);
            end
            repeat (3) @(negedge clk);
            checks++;
            if ({c_out, sum} !== exp) begin
                errors++;
                $display("FAIL result_hold got %b_%h exp %b_%h", c_out, sum, exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int last, n;
        logic [W:0] exp;
        last = -1; n = 0;
        exp = ref_add(8'h21, 8'h13, 1'b1);
        @(negedge clk);
        a_in = 8'h21; b_in = 8'h13; c_in = 1'b1; start = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (busy && done) begin
                checks++; errors++;
                $display("FAIL b2b_busy_done got both high at cycle %0d exp exclusive", k);
            end
            if (done) begin
                if (last >= 0) begin
                    checks++;
                    if (k - last !== W + 2) begin
                        errors++;
                        $display("FAIL b2b_period got %0d exp %0d", k - last, W + 2);
                    end
                end
                checks++;
                if ({c_out, sum} !== exp) begin
                    errors++;
                    $display("FAIL b2b_sum got %b_%h exp %b_%h", c_out, sum, exp[W], exp[W-1:0]);
                end
                last = k; n++;
            end
        end
        start = 1'b0;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL b2b_done_count got %0d exp 4", n); end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_start_during_run();
        int n;
        logic [W:0] exp;
        n = 0;
        exp = ref_add(8'h5A, 8'h33, 1'b0);
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h33; c_in = 1'b0; start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (done) begin
                n++;
                checks++;
                if ({c_out, sum} !== exp) begin
                    errors++;
                    $display("FAIL ignore_start_sum got %b_%h exp %b_%h", c_out, sum, exp[W], exp[W-1:0]);
                end
            end
            if (busy) begin
                start = 1'($urandom); a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (n !== 1) begin errors++; $display("FAIL ignore_start_count got %0d exp 1", n); end
    endtask

    task automatic test_reset_midrun();
        int lat, bcyc, n; logic [W-1:0] s; logic co; bit both;
        n = 0;
        do_op(8'hC3, 8'h5A, 1'b1, 1'b0, lat, bcyc, s, co, both);
        @(negedge clk);
        a_in = 8'h77; b_in = 8'h66; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b exp 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, c_out, sum} !== {3'b000, {W{1'b0}}}) begin
            errors++;
            $display("FAIL midrun_reset got busy=%b done=%b c_out=%b sum=%h exp all zero", busy, done, c_out, sum);
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) n++;
        end
        checks++;
        if (n !== 0) begin errors++; $display("FAIL midrun_no_done got %0d exp 0", n); end
        do_op(8'h10, 8'h20, 1'b0, 1'b0, lat, bcyc, s, co, both);
        checks++;
        if ({co, s} !== 9'h030) begin errors++; $display("FAIL after_reset_add got %b_%h exp 0_30", co, s); end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int lat, bcyc; logic [W-1:0] s; logic co; bit both;
        logic [W-1:0] a, b; logic [W:0] exp;
        do_op(8'h10, 8'h01, 1'b0, 1'b1, lat, bcyc, s, co, both);
        checks++;
        if ({co, s} !== 9'h10F) begin errors++; $display("FAIL sub_10_01 got %b_%h exp 1_0f", co, s); end
        do_op(8'h01, 8'h02, 1'b1, 1'b1, lat, bcyc, s, co, both);
        checks++;
        if ({co, s} !== 9'h0FF) begin errors++; $display("FAIL sub_01_02 got %b_%h exp 0_ff", co, s); end
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom);
            exp = ref_sub(a, b);
            do_op(a, b, 1'($urandom), 1'b1, lat, bcyc, s, co, both);
            checks++;
            if ({co, s} !== exp) begin
                errors++;
                $display("FAIL random_sub %h-%h got %b_%h exp %b_%h", a, b, co, s, exp[W], exp[W-1:0]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_start_during_run();
        test_reset_midrun();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
